// File: rtl/pe_cu_sequencer_if.sv
// Signal bundle between pe_cu_sequencer, its operand buffers, the compute unit and the result consumer.
// The sequencer takes the master view; the surrounding environment takes the slave view.
interface pe_cu_sequencer_if #(
  parameter int IDX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [31:0]      in_par;
  logic             in_last;
  logic             mode;

  logic             cu_enable;
  logic [31:0]      cu_data;
  logic [31:0]      cu_par;
  logic [1:0]       cu_sel;
  logic [31:0]      cu_out;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [IDX_W-1:0] res_index;

  modport master (
    input  in_valid, in_data, in_par, in_last, mode, cu_out, res_ready,
    output in_ready, cu_enable, cu_data, cu_par, cu_sel, res_valid, res_data, res_index
  );

  modport slave (
    output in_valid, in_data, in_par, in_last, mode, cu_out, res_ready,
    input  in_ready, cu_enable, cu_data, cu_par, cu_sel, res_valid, res_data, res_index
  );
endinterface

// File: rtl/pe_cu_sequencer.sv
// Sequences CU opcodes to reduce an operand stream into a dot product or an unsigned max search,
// returning the result and element count / first-max index over a valid/ready port.
module pe_cu_sequencer #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pe_cu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ADD,
    S_ACC,
    S_CMP,
    S_UPD,
    S_DONE
  } state_e;

  localparam logic [1:0] SEL_GT  = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;
  localparam logic [1:0] SEL_MUL = 2'b11;

  state_e           state_q, state_d;
  logic [31:0]      op_data_q, op_par_q;
  logic             op_last_q;
  logic             mode_q;
  logic [31:0]      acc_q;
  logic [31:0]      best_q;
  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             first_q;
  logic             fresh_q;
  logic [1:0]       cu_sel_q;
  logic [31:0]      cu_data_q, cu_par_q;

  logic             in_ready;
  logic             accept;
  logic             issue;
  logic             upd_hit;
  logic             res_valid;
  logic [1:0]       sel_d;
  logic [31:0]      data_d, par_d;

  // CU operands default to the last issued values so the CU bus holds while disabled.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    issue    = 1'b0;
    sel_d    = cu_sel_q;
    data_d   = cu_data_q;
    par_d    = cu_par_q;
    unique case (state_q)
      S_IDLE: begin
        in_ready = rst_n;
        if (bus.in_valid && rst_n) begin
          state_d = bus.mode ? S_CMP : S_MUL;
        end
      end
      S_MUL: begin
        issue   = 1'b1;
        sel_d   = SEL_MUL;
        data_d  = op_data_q;
        par_d   = op_par_q;
        state_d = S_ADD;
      end
      S_ADD: begin
        issue   = 1'b1;
        sel_d   = SEL_ADD;
        data_d  = acc_q;
        par_d   = bus.cu_out;
        state_d = S_ACC;
      end
      S_ACC: begin
        in_ready = ~op_last_q & rst_n;
        if (op_last_q) begin
          state_d = S_DONE;
        end else if (bus.in_valid) begin
          state_d = S_MUL;
        end
      end
      S_CMP: begin
        issue   = 1'b1;
        sel_d   = SEL_GT;
        data_d  = op_data_q;
        par_d   = best_q;
        state_d = S_UPD;
      end
      S_UPD: begin
        in_ready = ~op_last_q & rst_n;
        if (op_last_q) begin
          state_d = S_DONE;
        end else if (bus.in_valid) begin
          state_d = S_CMP;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept  = bus.in_valid && in_ready;
  assign upd_hit = first_q || bus.cu_out[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_data_q  <= '0;
      op_par_q   <= '0;
      op_last_q  <= 1'b0;
      mode_q     <= 1'b0;
      acc_q      <= '0;
      best_q     <= '0;
      count_q    <= '0;
      best_idx_q <= '0;
      first_q    <= 1'b0;
      fresh_q    <= 1'b0;
      cu_sel_q   <= '0;
      cu_data_q  <= '0;
      cu_par_q   <= '0;
    end else begin
      state_q <= state_d;
      // Marks the first ACC/UPD cycle of an element so a stalled stay does not repeat the update.
      fresh_q <= (state_q == S_ADD) || (state_q == S_CMP);

      if (issue) begin
        cu_sel_q  <= sel_d;
        cu_data_q <= data_d;
        cu_par_q  <= par_d;
      end

      if (accept) begin
        op_data_q <= bus.in_data;
        op_par_q  <= bus.in_par;
        op_last_q <= bus.in_last;
      end

      if (accept && (state_q == S_IDLE)) begin
        mode_q  <= bus.mode;
        acc_q   <= '0;
        count_q <= '0;
        first_q <= 1'b1;
      end

      if (fresh_q && (state_q == S_ACC)) begin
        acc_q   <= bus.cu_out;
        count_q <= count_q + IDX_W'(1);
      end

      if (fresh_q && (state_q == S_UPD)) begin
        if (upd_hit) begin
          best_q     <= op_data_q;
          best_idx_q <= count_q;
        end
        count_q <= count_q + IDX_W'(1);
        first_q <= 1'b0;
      end
    end
  end

  assign res_valid = (state_q == S_DONE);

  assign bus.in_ready  = in_ready;
  assign bus.cu_enable = issue;
  assign bus.cu_sel    = sel_d;
  assign bus.cu_data   = data_d;
  assign bus.cu_par    = par_d;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_valid ? (mode_q ? best_q : acc_q) : '0;
  assign bus.res_index = res_valid ? (mode_q ? best_idx_q : count_q) : '0;

endmodule

// File: tb/tb_pe_cu_sequencer.sv
// Directed bench for pe_cu_sequencer: a behavioural CU model plus hand-computed expected
// results, latencies and opcode sequences for dot product and max search vectors.
module tb_pe_cu_sequencer;
  localparam int IDX_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] selLog[$];

  pe_cu_sequencer_if #(.IDX_W(IDX_W)) bus ();

  pe_cu_sequencer #(.IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CU model: registered result, updated only in enabled cycles and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cu_out <= '0;
    end else if (bus.cu_enable) begin
      case (bus.cu_sel)
        2'b00:   bus.cu_out <= bus.cu_data - bus.cu_par;
        2'b01:   bus.cu_out <= {31'b0, bus.cu_data > bus.cu_par};
        2'b10:   bus.cu_out <= bus.cu_data + bus.cu_par;
        default: bus.cu_out <= bus.cu_data * bus.cu_par;
      endcase
    end
  end

  always @(negedge clk) begin
    if (bus.cu_enable === 1'b1) selLog.push_back(bus.cu_sel);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [31:0] p, input logic last,
                               input logic m, output int acceptCyc);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_par   = p;
    bus.in_last  = last;
    bus.mode     = m;
    for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    acceptCyc = cyc;
    checkOutput("accept_wait", {63'b0, bus.in_ready}, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output int resCyc);
    for (int i = 0; i < 60 && bus.res_valid !== 1'b1; i++) @(negedge clk);
    resCyc = cyc;
    checkOutput("res_wait", {63'b0, bus.res_valid}, 64'd1);
  endtask

  task automatic releaseResult();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput("rel_valid", {63'b0, bus.res_valid}, 64'd0);
    checkOutput("rel_ready", {63'b0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    int base, a0, a1, a2, a3, rc;
    logic [1:0] dotSel [6];
    dotSel = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_par    = '0;
    bus.in_last   = 1'b0;
    bus.mode      = 1'b0;
    bus.res_ready = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutput("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
    checkOutput("rst_cu_enable", {63'b0, bus.cu_enable}, 64'd0);
    checkOutput("rst_cu_sel", {62'b0, bus.cu_sel}, 64'd0);
    checkOutput("rst_cu_data", {32'b0, bus.cu_data}, 64'd0);
    checkOutput("rst_cu_par", {32'b0, bus.cu_par}, 64'd0);
    checkOutput("rst_res_valid", {63'b0, bus.res_valid}, 64'd0);
    checkOutput("rst_res_data", {32'b0, bus.res_data}, 64'd0);
    checkOutput("rst_res_index", {56'b0, bus.res_index}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", {63'b0, bus.in_ready}, 64'd1);

    // Dot product (1,2),(3,4),(5,6) back-to-back
    selLog.delete();
    base = cyc;
    applyStimulus(32'd1, 32'd2, 1'b0, 1'b0, a0);
    applyStimulus(32'd3, 32'd4, 1'b0, 1'b0, a1);
    applyStimulus(32'd5, 32'd6, 1'b1, 1'b0, a2);
    waitResult(rc);
    checkOutput("dot_acc0", 64'(a0 - base), 64'd0);
    checkOutput("dot_acc1", 64'(a1 - base), 64'd3);
    checkOutput("dot_acc2", 64'(a2 - base), 64'd6);
    checkOutput("dot_res_cyc", 64'(rc - base), 64'd10);
    checkOutput("dot_data", {32'b0, bus.res_data}, 64'd44);
    checkOutput("dot_index", {56'b0, bus.res_index}, 64'd3);
    checkOutput("dot_in_ready", {63'b0, bus.in_ready}, 64'd0);
    checkOutput("dot_hold_sel", {62'b0, bus.cu_sel}, 64'd2);
    checkOutput("dot_hold_data", {32'b0, bus.cu_data}, 64'd14);
    checkOutput("dot_hold_par", {32'b0, bus.cu_par}, 64'd30);
    checkOutput("dot_nops", 64'(selLog.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < selLog.size()) checkOutput($sformatf("dot_sel%0d", i), {62'b0, selLog[i]}, {62'b0, dotSel[i]});
    end
    releaseResult();

    // Max search 7,9,9,2
    selLog.delete();
    base = cyc;
    applyStimulus(32'd7, 32'd0, 1'b0, 1'b1, a0);
    applyStimulus(32'd9, 32'd0, 1'b0, 1'b1, a1);
    applyStimulus(32'd9, 32'd0, 1'b0, 1'b1, a2);
    applyStimulus(32'd2, 32'd0, 1'b1, 1'b1, a3);
    waitResult(rc);
    checkOutput("max_acc1", 64'(a1 - base), 64'd2);
    checkOutput("max_acc3", 64'(a3 - base), 64'd6);
    checkOutput("max_res_cyc", 64'(rc - base), 64'd9);
    checkOutput("max_data", {32'b0, bus.res_data}, 64'd9);
    checkOutput("max_index", {56'b0, bus.res_index}, 64'd1);
    checkOutput("max_hold_data", {32'b0, bus.cu_data}, 64'd2);
    checkOutput("max_hold_par", {32'b0, bus.cu_par}, 64'd9);
    checkOutput("max_nops", 64'(selLog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < selLog.size()) checkOutput($sformatf("max_sel%0d", i), {62'b0, selLog[i]}, 64'd1);
    end
    releaseResult();

    // Single zero element right after a max of 9: the first flag must force the update
    base = cyc;
    applyStimulus(32'd0, 32'd0, 1'b1, 1'b1, a0);
    waitResult(rc);
    checkOutput("zero_res_cyc", 64'(rc - base), 64'd3);
    checkOutput("zero_data", {32'b0, bus.res_data}, 64'd0);
    checkOutput("zero_index", {56'b0, bus.res_index}, 64'd0);
    releaseResult();

    // Wrap-around with an input gap, unlatched mode/last toggles and result back-pressure
    selLog.delete();
    base = cyc;
    applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, a0);
    bus.in_last = 1'b1;
    bus.mode    = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("gap_cu_enable", {63'b0, bus.cu_enable}, 64'd0);
    checkOutput("gap_in_ready", {63'b0, bus.in_ready}, 64'd1);
    checkOutput("gap_res_valid", {63'b0, bus.res_valid}, 64'd0);
    applyStimulus(32'd3, 32'd1, 1'b1, 1'b1, a1);
    waitResult(rc);
    checkOutput("wrap_acc1", 64'(a1 - base), 64'd6);
    checkOutput("wrap_res_cyc", 64'(rc - base), 64'd10);
    checkOutput("wrap_nops", 64'(selLog.size()), 64'd4);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_valid%0d", i), {63'b0, bus.res_valid}, 64'd1);
      checkOutput($sformatf("bp_data%0d", i), {32'b0, bus.res_data}, 64'h0000_0001);
      checkOutput($sformatf("bp_index%0d", i), {56'b0, bus.res_index}, 64'd2);
      checkOutput($sformatf("bp_in_ready%0d", i), {63'b0, bus.in_ready}, 64'd0);
      @(negedge clk);
    end
    releaseResult();

    // Reset in the middle of a dot vector
    applyStimulus(32'd3, 32'd3, 1'b0, 1'b0, a0);
    applyStimulus(32'd4, 32'd4, 1'b0, 1'b0, a1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_in_ready", {63'b0, bus.in_ready}, 64'd0);
    checkOutput("mid_cu_enable", {63'b0, bus.cu_enable}, 64'd0);
    checkOutput("mid_cu_sel", {62'b0, bus.cu_sel}, 64'd0);
    checkOutput("mid_cu_data", {32'b0, bus.cu_data}, 64'd0);
    checkOutput("mid_cu_par", {32'b0, bus.cu_par}, 64'd0);
    checkOutput("mid_res_data", {32'b0, bus.res_data}, 64'd0);
    checkOutput("mid_res_index", {56'b0, bus.res_index}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_res_valid%0d", i), {63'b0, bus.res_valid}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", {63'b0, bus.in_ready}, 64'd1);
    base = cyc;
    applyStimulus(32'd2, 32'd5, 1'b1, 1'b0, a0);
    waitResult(rc);
    checkOutput("post_rst_cyc", 64'(rc - base), 64'd4);
    checkOutput("post_rst_data", {32'b0, bus.res_data}, 64'd10);
    checkOutput("post_rst_index", {56'b0, bus.res_index}, 64'd1);
    releaseResult();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
